uc_sequencer: RTL and testbench
===============================

// Module: uc_sequencer
// PURPOSE
//  Control unit for the single-cycle microcontroller datapath. Decodes the 6-bit Opcode and
//  the zero flag into datapath controls (s_inc, s_inm, we, wez, ALUOp) plus a PC enable.
//  Sequences the core through run, start, halt and multi-cycle WAIT.
//  Sits beside the datapath: Opcode/zero in, controls out; pc_en gates the PC register.
// PARAMETERS
//  WAIT_UNIT  4  cycles per WAIT unit; WAIT nn stalls WAIT_UNIT*(nn+1) cycles (WAIT_UNIT>=1)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  Opcode     in   6  opcode of current instruction (from datapath)
//  zero       in   1  ALU zero flag (from datapath)
//  start      in   1  1-cycle pulse: IDLE->RUN, or HALTED->RUN (resume)
//  halt_req   in   1  external halt request; latched, honoured at next commit point
//  s_inc      out  1  1 = PC+1, 0 = jump address
//  s_inm      out  1  1 = immediate to register file, 0 = ALU result
//  we         out  1  register-file write enable
//  wez        out  1  zero-flag write enable
//  ALUOp      out  3  ALU operation select
//  pc_en      out  1  PC register load enable
//  running    out  1  1 in RUN or WAIT
//  halted     out  1  1 in HALTED
//  illegal_op out  1  sticky: undefined opcode executed; cleared by reset or start
// BEHAVIOUR
//  States: IDLE, RUN, WAIT, HALTED. Registered: state, cnt, halt_pend, illegal_op.
//  Controls are combinational from state/Opcode/zero/cnt (single-cycle datapath).
//  Reset (reset=0, async): state=IDLE, cnt=0, halt_pend=0, illegal_op=0.
//  Safe outputs (IDLE, HALTED, WAIT with cnt!=0): pc_en=0, we=0, wez=0, s_inc=1, s_inm=0, ALUOp=000.
//  IDLE/HALTED: start=1 -> RUN next cycle, illegal_op cleared. Other inputs ignored.
//  start is ignored in RUN and WAIT.
//  RUN decode (pc_en=1 unless noted; we/wez/s_inm=0, ALUOp=000, s_inc=1 unless noted):
//   000000 NOP
//   001aaa ALU   : ALUOp=aaa, we=1, wez=1
//   0100xx LOADI : s_inm=1, we=1
//   1000xx JMP   : s_inc=0
//   1001xx JZ    : s_inc=~zero
//   1010xx JNZ   : s_inc=zero
//   1100nn WAIT  : pc_en=0; cnt<=WAIT_UNIT*(nn+1)-1; ->WAIT
//   111111 HALT  : PC advances past HALT; ->HALTED
//   other  : treated as NOP; illegal_op<=1
//  WAIT: cnt decrements each cycle. At cnt==0: pc_en=1, s_inc=1, no writes, ->RUN.
//   WAIT instruction occupies WAIT_UNIT*(nn+1)+1 cycles total. cnt width = $clog2(4*WAIT_UNIT)+1.
//  halt_req: halt_pend<=1 on any cycle halt_req=1 (RUN or WAIT).
//   Commit point = any cycle with pc_en=1. If halt_pend (or halt_req) is set there, the instruction
//   still commits, then ->HALTED and halt_pend is cleared. halt_req never aborts a WAIT early.
//   halt_req in IDLE/HALTED is ignored (not latched).
//  Simultaneous HALT opcode + halt_req: single transition to HALTED; halt_pend cleared.
//  Resume from HALTED continues at the held PC (the instruction after the commit).
//  Reset mid-WAIT or mid-RUN: immediate IDLE, all registers cleared; no write strobe after reset edge.
//  running = (RUN|WAIT); halted = HALTED; both 0 in IDLE.
// TESTING
//  Reset: reset=0 -> state IDLE, pc_en=0, we=0, wez=0, s_inc=1, ALUOp=000, running=0, halted=0, illegal_op=0.
//  start pulse, Opcode=6'b001011 -> next cycle ALUOp=011, we=1, wez=1, s_inc=1, pc_en=1.
//  JZ 6'b100100: zero=1 -> s_inc=0, pc_en=1. zero=0 -> s_inc=1. JNZ gives the inverse.
//  WAIT 6'b110010, WAIT_UNIT=4: pc_en=0 for 12 cycles after decode, pc_en=1 on 13th, then RUN.
//  halt_req pulse during that WAIT: wait completes, PC advances, then halted=1. start resumes RUN.
//  Opcode 6'b011111 -> no writes, pc_en=1, illegal_op=1 sticky. Reset asserted mid-WAIT -> IDLE same cycle.

Source files
------------

// File: rtl/uc_sequencer.sv
// rtl/uc_sequencer.sv - control unit for the single-cycle microcontroller datapath
module uc_sequencer #(
    parameter int WAIT_UNIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       zero,
    input  logic       start,
    input  logic       halt_req,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we,
    output logic       wez,
    output logic [2:0] ALUOp,
    output logic       pc_en,
    output logic       running,
    output logic       halted,
    output logic       illegal_op
);

    localparam int CW = $clog2(4 * WAIT_UNIT) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            halt_pend, pend_nx, illegal_nx;

    logic op_nop, op_alu, op_loadi, op_jmp, op_jz, op_jnz, op_wait, op_halt, op_legal;
    logic halt_now;
    logic [CW-1:0] wait_load;

    assign op_nop   = (Opcode == 6'b000000);
    assign op_alu   = (Opcode[5:3] == 3'b001);
    assign op_loadi = (Opcode[5:2] == 4'b0100);
    assign op_jmp   = (Opcode[5:2] == 4'b1000);
    assign op_jz    = (Opcode[5:2] == 4'b1001);
    assign op_jnz   = (Opcode[5:2] == 4'b1010);
    assign op_wait  = (Opcode[5:2] == 4'b1100);
    assign op_halt  = (Opcode == 6'b111111);
    assign op_legal = op_nop | op_alu | op_loadi | op_jmp | op_jz | op_jnz | op_wait | op_halt;

    // Loaded so that the final WAIT cycle (cnt==0) is the commit cycle.
    assign wait_load = CW'(WAIT_UNIT * (int'(Opcode[1:0]) + 1) - 1);
    assign halt_now  = halt_pend | halt_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            halt_pend  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            halt_pend  <= pend_nx;
            illegal_op <= illegal_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_nx    = halt_pend;
        illegal_nx = illegal_op;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nx   = RUN;
                    illegal_nx = 1'b0;
                end
            end
            RUN: begin
                if (halt_req)
                    pend_nx = 1'b1;
                if (!op_legal)
                    illegal_nx = 1'b1;
                if (op_wait) begin
                    state_nx = WAIT;
                    cnt_nx   = wait_load;
                end else if (op_halt || halt_now) begin
                    state_nx = HALTED;
                    pend_nx  = 1'b0;
                end
            end
            WAIT: begin
                if (halt_req)
                    pend_nx = 1'b1;
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else if (halt_now) begin
                    state_nx = HALTED;
                    pend_nx  = 1'b0;
                end else begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pc_en   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        ALUOp   = 3'b000;
        running = (state == RUN) || (state == WAIT);
        halted  = (state == HALTED);
        case (state)
            RUN: begin
                pc_en = 1'b1;
                if (op_alu) begin
                    ALUOp = Opcode[2:0];
                    we    = 1'b1;
                    wez   = 1'b1;
                end
                if (op_loadi) begin
                    s_inm = 1'b1;
                    we    = 1'b1;
                end
                if (op_jmp)
                    s_inc = 1'b0;
                if (op_jz)
                    s_inc = ~zero;
                if (op_jnz)
                    s_inc = zero;
                if (op_wait)
                    pc_en = 1'b0;
            end
            WAIT: begin
                if (cnt == '0)
                    pc_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uc_sequencer.sv
// tb/tb_uc_sequencer.sv - directed scoreboard bench for uc_sequencer
module tb_uc_sequencer;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic       zero;
    logic       start;
    logic       halt_req;
    logic       s_inc, s_inm, we, wez, pc_en, running, halted, illegal_op;
    logic [2:0] ALUOp;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] ALU  = 6'b001011;
    localparam logic [5:0] HALT = 6'b111111;

    uc_sequencer #(.WAIT_UNIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .zero       (zero),
        .start      (start),
        .halt_req   (halt_req),
        .s_inc      (s_inc),
        .s_inm      (s_inm),
        .we         (we),
        .wez        (wez),
        .ALUOp      (ALUOp),
        .pc_en      (pc_en),
        .running    (running),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ev(input logic pc, input logic w, input logic wz,
                                       input logic si, input logic sm, input logic [2:0] alu,
                                       input logic r, input logic h, input logic il);
        return {pc, w, wz, si, sm, alu, r, h, il};
    endfunction

    function automatic logic [10:0] sf(input logic h, input logic il);
        return ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, h, il);
    endfunction

    function automatic logic [10:0] rn(input logic si, input logic il);
        return ev(1'b1, 1'b0, 1'b0, si, 1'b0, 3'b000, 1'b1, 1'b0, il);
    endfunction

    function automatic logic [10:0] wt(input logic il);
        return ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, il);
    endfunction

    task automatic check_out();
        logic [10:0] obs;
        logic [10:0] e;
        string       t;
        obs = {pc_en, we, wez, s_inc, s_inm, ALUOp, running, halted, illegal_op};
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (pc_en,we,wez,s_inc,s_inm,ALUOp,running,halted,illegal_op)",
                   t, obs, e);
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                       input logic z, input logic st, input logic hr, input logic [10:0] e);
        reset    = rst;
        Opcode   = op;
        zero     = z;
        start    = st;
        halt_req = hr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        Opcode   = NOP;
        zero     = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        @(posedge clk);
        #1;

        cyc("reset",         1'b0, ALU, 1'b0, 1'b0, 1'b0, sf(1'b0, 1'b0));
        cyc("reset_start",   1'b0, ALU, 1'b0, 1'b1, 1'b1, sf(1'b0, 1'b0));
        cyc("idle_hreq",     1'b1, ALU, 1'b0, 1'b0, 1'b1, sf(1'b0, 1'b0));
        cyc("idle_start",    1'b1, ALU, 1'b0, 1'b1, 1'b0, sf(1'b0, 1'b0));
        cyc("alu_011",       1'b1, ALU, 1'b0, 1'b0, 1'b0,
            ev(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 1'b0));
        cyc("start_in_run",  1'b1, 6'b001110, 1'b0, 1'b1, 1'b0,
            ev(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0));
        cyc("jz_zero1",      1'b1, 6'b100100, 1'b1, 1'b0, 1'b0, rn(1'b0, 1'b0));
        cyc("jz_zero0",      1'b1, 6'b100100, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b0));
        cyc("jnz_zero1",     1'b1, 6'b101010, 1'b1, 1'b0, 1'b0, rn(1'b1, 1'b0));
        cyc("jnz_zero0",     1'b1, 6'b101010, 1'b0, 1'b0, 1'b0, rn(1'b0, 1'b0));
        cyc("jmp",           1'b1, 6'b100011, 1'b1, 1'b0, 1'b0, rn(1'b0, 1'b0));
        cyc("loadi",         1'b1, 6'b010010, 1'b0, 1'b0, 1'b0,
            ev(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0));
        cyc("nop",           1'b1, NOP, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b0));
        cyc("illegal",       1'b1, 6'b011111, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b0));
        cyc("illegal_stick", 1'b1, NOP, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b1));

        // WAIT nn=2: decode plus 11 stalled cycles, then the commit cycle
        cyc("wait_decode",   1'b1, 6'b110010, 1'b0, 1'b0, 1'b0, wt(1'b1));
        for (int i = 1; i <= 11; i++)
            cyc($sformatf("wait_stall%0d", i), 1'b1, 6'b110010, 1'b0, 1'b0, (i == 3), wt(1'b1));
        cyc("wait_commit",   1'b1, 6'b110010, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b1));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("halted%0d", i), 1'b1, ALU, 1'b0, 1'b0, 1'b1, sf(1'b1, 1'b1));
        cyc("resume_start",  1'b1, ALU, 1'b0, 1'b1, 1'b0, sf(1'b1, 1'b1));
        cyc("resume_run",    1'b1, NOP, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b0));

        cyc("halt_and_req",  1'b1, HALT, 1'b0, 1'b0, 1'b1, rn(1'b1, 1'b0));
        cyc("halt_state",    1'b1, NOP, 1'b0, 1'b0, 1'b0, sf(1'b1, 1'b0));
        cyc("halt_start",    1'b1, NOP, 1'b0, 1'b1, 1'b0, sf(1'b1, 1'b0));
        cyc("after_halt_alu", 1'b1, 6'b001101, 1'b0, 1'b0, 1'b0,
            ev(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0));
        cyc("pend_cleared",  1'b1, NOP, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b0));

        // halt_req on the WAIT decode cycle must be latched and honoured after the wait
        cyc("wait0_decode",  1'b1, 6'b110000, 1'b0, 1'b0, 1'b1, wt(1'b0));
        for (int i = 1; i <= 3; i++)
            cyc($sformatf("wait0_stall%0d", i), 1'b1, 6'b110000, 1'b0, 1'b0, 1'b0, wt(1'b0));
        cyc("wait0_commit",  1'b1, 6'b110000, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b0));
        cyc("wait0_halted",  1'b1, NOP, 1'b0, 1'b0, 1'b0, sf(1'b1, 1'b0));
        cyc("wait0_start",   1'b1, NOP, 1'b0, 1'b1, 1'b0, sf(1'b1, 1'b0));

        cyc("illegal2",      1'b1, 6'b111110, 1'b0, 1'b0, 1'b0, rn(1'b1, 1'b0));
        cyc("wait3_decode",  1'b1, 6'b110011, 1'b0, 1'b0, 1'b0, wt(1'b1));
        cyc("wait3_stall1",  1'b1, 6'b110011, 1'b0, 1'b0, 1'b0, wt(1'b1));
        cyc("wait3_stall2",  1'b1, 6'b110011, 1'b0, 1'b0, 1'b0, wt(1'b1));
        cyc("reset_mid_wait", 1'b0, 6'b110011, 1'b0, 1'b0, 1'b0, sf(1'b0, 1'b0));
        cyc("post_reset",    1'b1, ALU, 1'b0, 1'b0, 1'b0, sf(1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
